// File: rtl/jtag_host_pkg.sv
// Shared types and sequence lengths for the host-side JTAG engine.
package jtag_host_pkg;

  // Command opcodes as presented on cmd_op.
  typedef enum logic [1:0] {
    OP_RESET    = 2'd0,
    OP_IDLE     = 2'd1,
    OP_SHIFT_IR = 2'd2,
    OP_SHIFT_DR = 2'd3
  } op_e;

  // Engine sequencing states.
  typedef enum logic [2:0] {
    ST_PARK,
    ST_PRE,
    ST_SHIFT,
    ST_POST,
    ST_RSP
  } state_e;

  // TCK counts of the fixed TMS walks around a scan.
  localparam int RESET_LEN  = 6;  // 1,1,1,1,1,0
  localparam int PRE_DR_LEN = 3;  // 1,0,0   Idle -> Shift-DR
  localparam int PRE_IR_LEN = 4;  // 1,1,0,0 Idle -> Shift-IR
  localparam int POST_LEN   = 2;  // 1,0     Exit1 -> Update -> Idle

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: low phase first, DIV clk per half-period, one-clk strobes
// marking the clk edge on which tck rises or falls.
module jtag_tck_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic trst,
  input  logic en_i,
  output logic tck_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tck_q, tck_d;
  logic          toggle;

  // Half-period counter; tck parks low and the phase restarts whenever disabled.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    cnt_d  = '0;
    tck_d  = 1'b0;
    toggle = en_i && (cnt_q == CW'(DIV - 1));
    if (en_i) begin
      cnt_d = toggle ? '0 : cnt_q + CW'(1);
      tck_d = tck_q ^ toggle;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge trst) begin
    // NOTE: non-blocking assignments so every flop sees pre-edge values of the others.
    if (!trst) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

  assign tck_o  = tck_q;
  assign rise_o = toggle && !tck_q;
  assign fall_o = toggle && tck_q;

endmodule

// File: rtl/jtag_host_engine.sv
// Host-side JTAG engine: walks the target TAP from Run-Test/Idle through
// RESET, IDLE and IR/DR scans, returning captured TDO on a response channel.
module jtag_host_engine
  import jtag_host_pkg::*;
#(
  parameter  int DIV    = 2,
  parameter  int MAXLEN = 32,
  localparam int LW     = $clog2(MAXLEN)
) (
  input  logic              clk,
  input  logic              trst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LW-1:0]     cmd_len,
  input  logic [MAXLEN-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [MAXLEN-1:0] rsp_data,
  output logic              busy,
  output logic              tck,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo,
  output logic              tap_trst_n
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [LW-1:0]     len_q, len_d;
  logic [LW-1:0]     idx_q, idx_d;
  logic [LW-1:0]     last_idx;
  logic [MAXLEN-1:0] data_q, data_d;
  logic [MAXLEN-1:0] cap_q, cap_d;
  logic              tms_q, tms_d;
  logic              tdi_q, tdi_d;
  logic              trst_n_q;
  logic              tck_rise, tck_fall;

  // TMS level for TCK number idx of the given phase.
  function automatic logic seq_tms(state_e st, op_e op, logic [LW-1:0] idx,
                                   logic [LW-1:0] len);
    logic t;
    t = 1'b0;
    case (st)
      ST_PRE: begin
        case (op)
          OP_RESET:    t = (idx < LW'(RESET_LEN - 1));
          OP_SHIFT_DR: t = (idx < LW'(PRE_DR_LEN - 2));
          OP_SHIFT_IR: t = (idx < LW'(PRE_IR_LEN - 2));
          default:     t = 1'b0;
        endcase
      end
      ST_SHIFT: t = (idx == len);
      ST_POST:  t = (idx == '0);
      default:  t = 1'b0;
    endcase
    return t;
  endfunction

  jtag_tck_gen #(.DIV(DIV)) u_tck_gen (
    .clk    (clk),
    .trst   (trst),
    .en_i   (busy && trst_n_q),
    .tck_o  (tck),
    .rise_o (tck_rise),
    .fall_o (tck_fall)
  );

  // Index of the final TCK in the current phase.
  always_comb begin
    last_idx = '0;
    case (state_q)
      ST_PRE: begin
        case (op_q)
          OP_RESET:    last_idx = LW'(RESET_LEN - 1);
          OP_IDLE:     last_idx = len_q;
          OP_SHIFT_DR: last_idx = LW'(PRE_DR_LEN - 1);
          default:     last_idx = LW'(PRE_IR_LEN - 1);
        endcase
      end
      ST_SHIFT: last_idx = len_q;
      ST_POST:  last_idx = LW'(POST_LEN - 1);
      default:  last_idx = '0;
    endcase
  end

  // Next-state: accept, advance one TCK per fall strobe, capture TDO on rise.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    len_d   = len_q;
    data_d  = data_q;
    idx_d   = idx_q;
    cap_d   = cap_q;
    case (state_q)
      ST_PARK: begin
        if (cmd_valid) begin
          state_d = ST_PRE;
          op_d    = op_e'(cmd_op);
          len_d   = cmd_len;
          data_d  = cmd_data;
          idx_d   = '0;
          cap_d   = '0;
        end
      end
      ST_PRE, ST_SHIFT, ST_POST: begin
        if (tck_rise && state_q == ST_SHIFT) cap_d[idx_q] = tdo;
        if (tck_fall) begin
          if (idx_q != last_idx) begin
            idx_d = idx_q + LW'(1);
          end else begin
            idx_d = '0;
            case (state_q)
              ST_PRE:   state_d = (op_q == OP_SHIFT_IR || op_q == OP_SHIFT_DR) ? ST_SHIFT : ST_PARK;
              ST_SHIFT: state_d = ST_POST;
              default:  state_d = ST_RSP;
            endcase
          end
        end
      end
      ST_RSP:  if (rsp_ready) state_d = ST_PARK;
      default: state_d = ST_PARK;
    endcase
    // Pins follow the position being entered, so they change with the tck fall.
    tms_d = seq_tms(state_d, op_d, idx_d, len_d);
    tdi_d = (state_d == ST_SHIFT) ? data_d[idx_d] : 1'b0;
  end

  // Engine registers; reset lands in the pending auto-RESET sequence.
  always_ff @(posedge clk or negedge trst) begin
    if (!trst) begin
      state_q  <= ST_PRE;
      op_q     <= OP_RESET;
      len_q    <= '0;
      data_q   <= '0;
      idx_q    <= '0;
      cap_q    <= '0;
      tms_q    <= 1'b1;
      tdi_q    <= 1'b0;
      trst_n_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      len_q    <= len_d;
      data_q   <= data_d;
      idx_q    <= idx_d;
      cap_q    <= cap_d;
      tms_q    <= tms_d;
      tdi_q    <= tdi_d;
      trst_n_q <= 1'b1;
    end
  end

  assign cmd_ready  = (state_q == ST_PARK);
  assign rsp_valid  = (state_q == ST_RSP);
  assign busy       = (state_q == ST_PRE) || (state_q == ST_SHIFT) || (state_q == ST_POST);
  assign rsp_data   = cap_q;
  assign tms        = tms_q;
  assign tdi        = tdi_q;
  assign tap_trst_n = trst_n_q;

endmodule
